adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Parametrised, pipelined add/subtract unit with carry-in, 4-bit status flags and valid/ready flow control.
//  Splits the carry chain into CHUNK-bit slices, one register stage per slice, so wide operands meet timing.
//  Sits between the ALU operand mux and the result/status writeback, and replaces the single-cycle adder path.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
//  CHUNK   8  bits resolved per pipeline stage; STAGES = ceil(WIDTH/CHUNK); last slice may be narrower
// PORTS
//  clk        in   1          rising-edge clock; single clock domain
//  reset      in   1          synchronous, active-high reset
//  inValid    in   1          operands/opMode/carryIn valid this cycle
//  inReady    out  1          unit accepts input this cycle (transfer = inValid & inReady)
//  operand1   in   WIDTH      A
//  operand2   in   WIDTH      B
//  opMode     in   2          OP_ADD=0 A+B, OP_SUB=1 A-B, OP_ADC=2 A+B+cin, OP_SBC=3 A-B-!cin
//  carryIn    in   1          cin; ignored for OP_ADD/OP_SUB
//  outValid   out  1          result/statusOut valid
//  outReady   in   1          consumer accepts (transfer = outValid & outReady)
//  result     out  WIDTH      sum/difference, modulo 2^WIDTH (wraps, e.g. FF+01=00 at WIDTH=8)
//  statusOut  out  4          flags, indexed by ST_CARRY=0, ST_ZERO=1, ST_NEG=2, ST_OVERFLOW=3
// BEHAVIOUR
//  - Arithmetic: Beff = (SUB|SBC) ? ~B : B; c0 = ADD:0, SUB:1, ADC/SBC:carryIn; {C,result} = A + Beff + c0.
//  - ST_CARRY = carry-out of that sum (for subtract: 1 = no borrow). ST_NEG = result[WIDTH-1].
//  - ST_ZERO = (result == 0), computed over the full word. It is not valid as a per-slice OR.
//  - ST_OVERFLOW = (A[W-1] == Beff[W-1]) & (result[W-1] != A[W-1]). It uses the Beff sign, not the A sign twice.
//  - Pipeline: stage k adds slice k with the carry registered from stage k-1.
//    Each stage carries forward the not-yet-added upper operand bits and the already-computed lower result bits.
//    Stage k also carries forward the Beff MSB, A MSB and a running zero flag.
//  - Latency: exactly STAGES cycles from accept to outValid, when not stalled. Throughput: 1 op/cycle.
//  - Flow control: one global stall.
//    - inReady = !outValid | outReady, and the whole pipe advances only when inReady=1.
//    - Per-stage valid bits travel with the data, so bubbles are allowed.
//  - While stalled (outValid=1, outReady=0), result/statusOut/outValid hold stable and no stage register changes.
//  - A transfer-in and a transfer-out in the same cycle are legal; both occur, with no loss or duplication.
//  - Results leave in issue order.
//  - Reset (any cycle, including mid-stream): all stage valid bits go to 0 and in-flight ops are discarded.
//    outValid=0, result=0, statusOut=4'b0000 on the cycle after reset is sampled high.
//    inReady=1 while reset=0 and the pipe is empty.
//  - inValid=0 inserts a bubble. The bubble does not block later ops except through the global stall.
//  - STAGES=1 (CHUNK>=WIDTH): degenerates to one registered stage, latency 1, identical flags.
//  - Data inputs are don't-care when inValid=0 and must not affect state.
// STRUCTURE
//  - Package adder_pkg: ST_CARRY/ST_ZERO/ST_NEG/ST_OVERFLOW indices, OP_ADD/OP_SUB/OP_ADC/OP_SBC codes,
//    and a STAGES calc function.
//  - Sub-module adder_slice: purely combinational. Inputs a[CHUNK], b[CHUNK], cin. Outputs sum[CHUNK], cout, zero.
//    It is instantiated once per stage via generate. Stage registers and handshake live in adder_pipe.
// TESTING (WIDTH=8, CHUNK=4 -> STAGES=2 unless noted)
//  1. ADD FF+01 -> result 00, statusOut C=1,Z=1,N=0,V=0; outValid exactly 2 cycles after accept.
//  2. ADD 7F+01 -> 80, N=1,V=1,C=0,Z=0. SUB 80-01 -> 7F, V=1,C=1,N=0.
//  3. SUB 05-07 -> FE, C=0,N=1,V=0. SBC 10-01 with cin=0 -> 0E, C=1. ADC FF+00 with cin=1 -> 00, C=1,Z=1.
//  4. Back-to-back stream of 8 random ops with outReady low for 3 cycles mid-stream:
//     inReady drops, outputs held stable, all 8 results match the reference model in order.
//  5. Reset asserted with 2 ops in flight -> next cycle outValid=0, result=00, statusOut=0.
//     Nothing from those ops ever appears.
//  6. WIDTH=32, CHUNK=8 and WIDTH=13, CHUNK=4 (ragged last slice): 10k random ops checked vs model.
//     Latency must be 4 cycles in both configurations.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: status flag indices, op codes, stage count.
package adder_pkg;

  localparam int ST_CARRY    = 0;
  localparam int ST_ZERO     = 1;
  localparam int ST_NEG      = 2;
  localparam int ST_OVERFLOW = 3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;

  function automatic int calc_stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry-chain slice: CHUNK-bit add with carry in/out and slice-local zero detect.
// Purely combinational; the enclosing pipe owns all registers and handshake.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             zero_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
  assign zero_o          = (sum_o == '0);

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub with flags: one CHUNK-bit carry slice per stage, latency STAGES cycles, 1 op/cycle.
// Single global stall: the whole pipe freezes while the output is valid and not accepted.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       opMode,
  input  logic             carryIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  // Stage k inputs come from the ports (k=0) or from stage k-1 registers.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_in [STAGES];
  logic             c_in [STAGES];
  logic             z_in [STAGES];
  logic             v_in [STAGES];

  logic [WIDTH-1:0] r_d  [STAGES];
  logic             c_d  [STAGES];
  logic             z_d  [STAGES];

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic             z_q   [STAGES];
  logic [3:0]       status_q;
  logic [3:0]       status_d;

  logic             sub_op;
  logic             c0;
  logic [WIDTH-1:0] b_eff;

  assign outValid  = vld_q[LAST];
  assign inReady   = !outValid || outReady;
  assign result    = r_q[LAST];
  assign statusOut = status_q;

  always_comb begin
    sub_op = (opMode == OP_SUB) || (opMode == OP_SBC);
    b_eff  = sub_op ? ~operand2 : operand2;
    c0     = carryIn;
    if (opMode == OP_ADD) c0 = 1'b0;
    if (opMode == OP_SUB) c0 = 1'b1;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int SW = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;
    localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;

    logic [SW-1:0] s_sum;
    logic          s_cout;
    logic          s_zero;
    logic          unused_k;

    if (k == 0) begin : g_head
      assign a_in[k] = operand1;
      assign b_in[k] = b_eff;
      assign r_in[k] = '0;
      assign c_in[k] = c0;
      assign z_in[k] = 1'b1;
      assign v_in[k] = inValid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign r_in[k] = r_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign z_in[k] = z_q[k-1];
      assign v_in[k] = vld_q[k-1];
    end

    adder_slice #(.CHUNK(SW)) u_slice (
      .a_i    (a_in[k][LO +: SW]),
      .b_i    (b_in[k][LO +: SW]),
      .cin_i  (c_in[k]),
      .sum_o  (s_sum),
      .cout_o (s_cout),
      .zero_o (s_zero)
    );

    // Merge this slice into the partial result; the zero flag accumulates across slices.
    assign r_d[k] = (r_in[k] & ~MASK) | (WIDTH'(s_sum) << LO);
    assign c_d[k] = s_cout;
    assign z_d[k] = z_in[k] & s_zero;

    assign unused_k = ^{a_q[k], b_q[k], c_q[k], z_q[k]};
  end

  always_comb begin
    status_d              = '0;
    status_d[ST_CARRY]    = c_d[LAST];
    status_d[ST_ZERO]     = z_d[LAST];
    status_d[ST_NEG]      = r_d[LAST][WIDTH-1];
    status_d[ST_OVERFLOW] = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                            (r_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        z_q[k]   <= 1'b0;
      end
      status_q <= '0;
    end else if (inReady) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          r_q[k] <= r_d[k];
          c_q[k] <= c_d[k];
          z_q[k] <= z_d[k];
        end
      end
      if (v_in[LAST]) status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and randomized checks of adder_pipe at 8/4, 32/8 and 13/4 (ragged) configurations.
module tb_adder_pipe;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_vld8, in_rdy8, cin8, out_vld8, out_rdy8;
  logic [7:0] a8, b8, res8;
  logic [1:0] op8;
  logic [3:0] st8;

  logic        in_vld, cin_b, out_rdy;
  logic [1:0]  op_b;
  logic [31:0] a_b, b_b;
  logic        in_rdy32, out_vld32, in_rdy13, out_vld13;
  logic [31:0] res32;
  logic [12:0] res13;
  logic [3:0]  st32, st13;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] q8[$];
  logic [35:0] q32[$];
  logic [35:0] q13[$];

  adder_pipe #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .reset(reset), .inValid(in_vld8), .inReady(in_rdy8),
    .operand1(a8), .operand2(b8), .opMode(op8), .carryIn(cin8),
    .outValid(out_vld8), .outReady(out_rdy8), .result(res8), .statusOut(st8));

  adder_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .reset(reset), .inValid(in_vld), .inReady(in_rdy32),
    .operand1(a_b), .operand2(b_b), .opMode(op_b), .carryIn(cin_b),
    .outValid(out_vld32), .outReady(out_rdy), .result(res32), .statusOut(st32));

  adder_pipe #(.WIDTH(13), .CHUNK(4)) dut13 (
    .clk(clk), .reset(reset), .inValid(in_vld), .inReady(in_rdy13),
    .operand1(a_b[12:0]), .operand2(b_b[12:0]), .opMode(op_b), .carryIn(cin_b),
    .outValid(out_vld13), .outReady(out_rdy), .result(res13), .statusOut(st13));

  // Reference: full-width arithmetic, returns {V,N,Z,C, result zero-extended to 32 bits}.
  function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic cin);
    logic [63:0] mask, ae, be, full;
    logic [31:0] r;
    logic c, z, n, v;
    mask = (64'd1 << w) - 64'd1;
    ae   = {32'd0, a} & mask;
    be   = {32'd0, b} & mask;
    if (op == 2'd1 || op == 2'd3) be = ~be & mask;
    full = ae + be + ((op == 2'd0) ? 64'd0 : (op == 2'd1) ? 64'd1 : {63'd0, cin});
    r    = 32'(full & mask);
    c    = full[w];
    z    = (r == 32'd0);
    n    = r[w-1];
    v    = (ae[w-1] == be[w-1]) && (n != ae[w-1]);
    return {v, n, z, c, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic c,
                          input logic [7:0] er, input logic [3:0] es);
    op8 = o; a8 = a; b8 = b; cin8 = c; in_vld8 = 1'b1;
    @(negedge clk);
    in_vld8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom); cin8 = 1'($urandom);
    check({tag, "_early"}, 64'(out_vld8), 64'd0);
    @(negedge clk);
    check({tag, "_vld"}, 64'(out_vld8), 64'd1);
    check({tag, "_res"}, 64'(res8), 64'(er));
    check({tag, "_st"}, 64'(st8), 64'(es));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] va[8], vb[8];
    logic [1:0] vo[8];
    logic       vc[8];
    int issued, popped, cyc, nstall, seen, lat32, lat13, n32, n13;
    logic [35:0] exp32, exp13;

    reset = 1'b1;
    in_vld8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; cin8 = 1'b0; out_rdy8 = 1'b1;
    in_vld = 1'b0; a_b = '0; b_b = '0; op_b = '0; cin_b = 1'b0; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", 64'(out_vld8), 64'd0);
    check("rst_res", 64'(res8), 64'd0);
    check("rst_st", 64'(st8), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_inrdy", 64'(in_rdy8), 64'd1);
    @(negedge clk);

    // Hand-computed vectors; status is {V,N,Z,C}.
    directed("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011);
    directed("add_7f_01", OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1100);
    directed("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1001);
    directed("sub_05_07", OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b0100);
    directed("sbc_10_01", OP_SBC, 8'h10, 8'h01, 1'b0, 8'h0E, 4'b0001);
    directed("adc_ff_00", OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011);
    directed("sub_03_03", OP_SUB, 8'h03, 8'h03, 1'b0, 8'h00, 4'b0011);
    directed("add_10_0f", OP_ADD, 8'h10, 8'h0F, 1'b1, 8'h1F, 4'b0000);

    // Back-to-back stream with a 3-cycle consumer stall.
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vo[i] = 2'($urandom); vc[i] = 1'($urandom);
    end
    issued = 0; popped = 0; cyc = 0; nstall = 0;
    while ((issued < 8 || popped < 8) && cyc < 40) begin
      out_rdy8 = !(cyc >= 4 && cyc <= 6);
      if (issued < 8) begin
        in_vld8 = 1'b1; a8 = va[issued]; b8 = vb[issued]; op8 = vo[issued]; cin8 = vc[issued];
      end else begin
        in_vld8 = 1'b0;
      end
      #1;
      if (out_vld8 && !out_rdy8) begin
        nstall++;
        check("stall_inrdy", 64'(in_rdy8), 64'd0);
        if (q8.size() > 0) check("stall_hold", 64'({st8, 24'd0, res8}), 64'(q8[0]));
      end
      if (out_vld8 && out_rdy8) begin
        if (q8.size() > 0) check("stream_res", 64'({st8, 24'd0, res8}), 64'(q8.pop_front()));
        else check("stream_extra", 64'(out_vld8), 64'd0);
        popped++;
      end
      if (in_vld8 && in_rdy8) begin
        q8.push_back(model(8, 32'(a8), 32'(b8), op8, cin8));
        issued++;
      end
      @(negedge clk);
      cyc++;
    end
    in_vld8 = 1'b0; out_rdy8 = 1'b1;
    check("stream_issued", 64'(issued), 64'd8);
    check("stream_popped", 64'(popped), 64'd8);
    check("stall_cycles", 64'(nstall), 64'd3);

    // Reset with two ops in flight: nothing from them may appear.
    op8 = OP_ADD; a8 = 8'h11; b8 = 8'h22; in_vld8 = 1'b1;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    in_vld8 = 1'b0; out_rdy8 = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", 64'(out_vld8), 64'd0);
    check("mid_rst_res", 64'(res8), 64'd0);
    check("mid_rst_st", 64'(st8), 64'd0);
    reset = 1'b0; out_rdy8 = 1'b1;
    seen = 0;
    repeat (6) begin
      #1;
      if (out_vld8) seen++;
      @(negedge clk);
    end
    check("mid_rst_flush", 64'(seen), 64'd0);

    // Latency of the wide and ragged configurations from an empty pipe.
    a_b = 32'h8000_0FFF; b_b = 32'h7FFF_F001; op_b = OP_ADD; cin_b = 1'b0; in_vld = 1'b1;
    exp32 = model(32, a_b, b_b, op_b, cin_b);
    exp13 = model(13, a_b, b_b, op_b, cin_b);
    @(negedge clk);
    in_vld = 1'b0; a_b = $urandom; b_b = $urandom;
    lat32 = -1; lat13 = -1;
    for (int k = 1; k <= 8; k++) begin
      if (out_vld32 && lat32 < 0) begin
        lat32 = k;
        check("lat32_res", 64'({st32, res32}), 64'(exp32));
      end
      if (out_vld13 && lat13 < 0) begin
        lat13 = k;
        check("lat13_res", 64'({st13, 19'd0, res13}), 64'(exp13));
      end
      @(negedge clk);
    end
    check("lat32", 64'(lat32), 64'd4);
    check("lat13", 64'(lat13), 64'd4);

    // Random traffic with bubbles and backpressure on both wide configurations.
    n32 = 0; n13 = 0; cyc = 0;
    while ((n32 < 10000 || n13 < 10000 || q32.size() > 0 || q13.size() > 0) && cyc < 30000) begin
      in_vld  = (n32 < 10000 || n13 < 10000) && ($urandom_range(0, 9) < 8);
      out_rdy = ($urandom_range(0, 9) < 8);
      a_b = $urandom; b_b = $urandom; op_b = 2'($urandom); cin_b = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b_b = a_b;
      #1;
      if (out_vld32 && out_rdy) begin
        if (q32.size() > 0) check("rand32", 64'({st32, res32}), 64'(q32.pop_front()));
        else check("rand32_extra", 64'(out_vld32), 64'd0);
      end
      if (out_vld13 && out_rdy) begin
        if (q13.size() > 0) check("rand13", 64'({st13, 19'd0, res13}), 64'(q13.pop_front()));
        else check("rand13_extra", 64'(out_vld13), 64'd0);
      end
      if (in_vld && in_rdy32) begin
        q32.push_back(model(32, a_b, b_b, op_b, cin_b));
        n32++;
      end
      if (in_vld && in_rdy13) begin
        q13.push_back(model(13, a_b, b_b, op_b, cin_b));
        n13++;
      end
      @(negedge clk);
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    check("rand_in_time", 64'(cyc < 30000), 64'd1);
    check("rand32_drained", 64'(q32.size()), 64'd0);
    check("rand13_drained", 64'(q13.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
